// File: rtl/path_capture_buffer_if.sv
// CPU store-snoop bus plus consumer read/ack port of the path capture buffer.
// master = CPU/consumer side, slave = capture block.
interface path_capture_buffer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              path_found;
  logic              done_pulse;
  logic              overflow;
  logic              path_ack;

  modport master (
    output MemWrite, DataAdr, WriteData, rd_idx, path_ack,
    input  rd_data, count, path_found, done_pulse, overflow
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, rd_idx, path_ack,
    output rd_data, count, path_found, done_pulse, overflow
  );
endinterface

// File: rtl/path_capture_buffer.sv
// Snoops CPU stores to a path-data address, buffers up to DEPTH words and
// flags path completion on a done store until the consumer acknowledges.
module path_capture_buffer #(
  parameter int unsigned     DATA_W    = 32,
  parameter int unsigned     ADDR_W    = 32,
  parameter int unsigned     DEPTH     = 16,
  parameter logic [ADDR_W-1:0] PATH_ADDR = 32'h0200_0008,
  parameter logic [ADDR_W-1:0] DONE_ADDR = 32'h0200_000C,
  parameter logic [ADDR_W-1:0] CLR_ADDR  = 32'h0200_0010
) (
  input  logic                   clk,
  input  logic                   reset,
  path_capture_buffer_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_pulse_q, done_pulse_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];

  logic is_path, is_done, is_clr;
  assign is_path = bus.MemWrite && (bus.DataAdr == PATH_ADDR);
  assign is_done = bus.MemWrite && (bus.DataAdr == DONE_ADDR)
                   && (bus.WriteData == DATA_W'(1));
  assign is_clr  = bus.MemWrite && (bus.DataAdr == CLR_ADDR);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    done_pulse_d = 1'b0;
    wr_en        = 1'b0;
    if (is_clr) begin
      state_d    = CAPTURE;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        CAPTURE: begin
          if (is_path) begin
            if (count_q < CNT_W'(DEPTH)) begin
              wr_en   = 1'b1;
              count_d = count_q + CNT_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else if (is_done) begin
            state_d      = DONE;
            done_pulse_d = 1'b1;
          end
        end
        DONE: begin
          // Stores arriving with the ack are judged against DONE and dropped.
          if (bus.path_ack) begin
            state_d    = CAPTURE;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
        default: state_d = CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CAPTURE;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      done_pulse_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      done_pulse_q <= done_pulse_d;
      rd_data_q    <= (CNT_W'(bus.rd_idx) < count_q) ? mem[bus.rd_idx] : '0;
    end
  end

  // Buffer RAM is not reset; the write pointer is the entry count.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[count_q[IDX_W-1:0]] <= bus.WriteData;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.count      = count_q;
  assign bus.path_found = (state_q == DONE);
  assign bus.done_pulse = done_pulse_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_path_capture_buffer.sv
// Directed bench for path_capture_buffer: read-port expectations queued on
// drive and compared when the registered data appears.
module tb_path_capture_buffer;
  localparam logic [31:0] PATH_A = 32'h0200_0008;
  localparam logic [31:0] DONE_A = 32'h0200_000C;
  localparam logic [31:0] CLR_A  = 32'h0200_0010;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  path_capture_buffer_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(16)) bus ();

  path_capture_buffer #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16),
    .PATH_ADDR(PATH_A), .DONE_ADDR(DONE_A), .CLR_ADDR(CLR_A)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = addr;
    bus.WriteData = data;
    tick();
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp);
    logic [31:0] e;
    bus.rd_idx = 4'(idx);
    sb.push_back(exp);
    tick();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL rd_queue observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk($sformatf("rd[%0d]", idx), bus.rd_data, e);
    end
  endtask

  task automatic ack();
    bus.path_ack = 1'b1;
    tick();
    bus.path_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    bus.rd_idx = '0; bus.path_ack = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_found", 32'(bus.path_found), 0);
    chk("rst_pulse", 32'(bus.done_pulse), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_rd", bus.rd_data, 0);
    reset = 1'b0;
    tick();

    // 9-entry path, then done
    for (int i = 0; i < 9; i++) store(PATH_A, 32'h10 + 32'(i));
    chk("count9", 32'(bus.count), 9);
    chk("found_before_done", 32'(bus.path_found), 0);
    store(DONE_A, 1);
    chk("pulse_hi", 32'(bus.done_pulse), 1);
    chk("found_hi", 32'(bus.path_found), 1);
    tick();
    chk("pulse_lo", 32'(bus.done_pulse), 0);
    for (int i = 0; i < 9; i++) rd(i, 32'h10 + 32'(i));
    rd(9, 0);

    // stores ignored in DONE
    store(PATH_A, 32'h55);
    chk("done_frozen_count", 32'(bus.count), 9);
    rd(8, 32'h18);
    rd(9, 0);
    ack();
    chk("ack_found", 32'(bus.path_found), 0);
    chk("ack_count", 32'(bus.count), 0);
    chk("ack_ovf", 32'(bus.overflow), 0);
    store(PATH_A, 32'hAA);
    chk("rearm_count", 32'(bus.count), 1);
    rd(0, 32'hAA);
    ack();
    chk("ack_in_capture", 32'(bus.count), 1);

    // done data other than 1 ignored; empty path
    store(DONE_A, 2);
    chk("done2_found", 32'(bus.path_found), 0);
    chk("done2_pulse", 32'(bus.done_pulse), 0);
    store(CLR_A, 32'h1234);
    chk("clr_count", 32'(bus.count), 0);
    store(DONE_A, 1);
    chk("empty_found", 32'(bus.path_found), 1);
    chk("empty_count", 32'(bus.count), 0);
    ack();

    // overflow at DEPTH=16
    for (int i = 0; i < 16; i++) store(PATH_A, 32'h100 + 32'(i));
    chk("full_count", 32'(bus.count), 16);
    chk("full_ovf", 32'(bus.overflow), 0);
    store(PATH_A, 32'h1FF);
    chk("ovf17", 32'(bus.overflow), 1);
    chk("count17", 32'(bus.count), 16);
    store(PATH_A, 32'h1FE);
    chk("count18", 32'(bus.count), 16);
    rd(15, 32'h10F);
    store(DONE_A, 1);
    chk("ovf_done_found", 32'(bus.path_found), 1);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    rd(0, 32'h100);

    // ack together with a path store
    bus.path_ack = 1'b1;
    store(PATH_A, 32'h77);
    bus.path_ack = 1'b0;
    chk("ackst_found", 32'(bus.path_found), 0);
    chk("ackst_count", 32'(bus.count), 0);
    chk("ackst_ovf", 32'(bus.overflow), 0);
    rd(0, 0);
    store(PATH_A, 32'h88);
    rd(0, 32'h88);

    // clear mid-capture
    store(CLR_A, 0);
    for (int i = 0; i < 5; i++) store(PATH_A, 32'h200 + 32'(i));
    chk("pre_clr_count", 32'(bus.count), 5);
    store(CLR_A, 0);
    chk("clr5_count", 32'(bus.count), 0);
    chk("clr5_found", 32'(bus.path_found), 0);
    store(DONE_A, 1);
    chk("clr5_capture", 32'(bus.path_found), 1);
    store(CLR_A, 0);
    chk("clr_in_done", 32'(bus.path_found), 0);

    // reset during DONE
    for (int i = 0; i < 3; i++) store(PATH_A, 32'h300 + 32'(i));
    store(DONE_A, 1);
    rd(1, 32'h301);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstdone_found", 32'(bus.path_found), 0);
    chk("rstdone_count", 32'(bus.count), 0);
    chk("rstdone_rd", bus.rd_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
